// File: rtl/ariane_pkg.sv
// Shared CVA6-side types: the riscv address width and the runtime-monitor lane
// handshake structs and lane-state enum used by the release tracker.
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  // Lane index field is sized for up to 16 monitor lanes.
  localparam int unsigned RM_LANE_W = 4;

  typedef struct packed {
    logic                     monitor_ins;
    logic [RM_LANE_W-1:0]     lane;
    logic [riscv::VLEN-1:0]   pc;
  } runtime_monitor_ctrl;

  typedef struct packed {
    logic                 reset_lane;
    logic [RM_LANE_W-1:0] lane;
  } lane_ctrl;

  typedef enum logic [1:0] {
    LANE_IDLE    = 2'd0,
    LANE_PENDING = 2'd1,
    LANE_CHECK   = 2'd2,
    LANE_RELEASE = 2'd3
  } lane_state_e;

  typedef struct packed {
    lane_state_e            state;
    logic [riscv::VLEN-1:0] pc;
  } lane_rec_t;
endpackage

// File: rtl/rm_lane_slot.sv
// One monitor lane: tracks an allocated instruction PC from allocation through
// commit, a fixed check delay, and a single-cycle release.
module rm_lane_slot
  import ariane_pkg::*;
#(
  parameter int unsigned CHECK_LATENCY = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alloc_i,
  input  logic [riscv::VLEN-1:0] alloc_pc_i,
  input  logic                   commit_i,
  input  logic                   flush_i,
  output lane_rec_t              rec_o
);

  localparam int unsigned CW = $clog2(CHECK_LATENCY + 1);

  lane_state_e            state_q, state_d;
  logic [riscv::VLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LANE_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Allocation overrides everything, so a lane in its release cycle is
  // re-armed directly instead of passing through IDLE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (alloc_i) begin
      state_d = LANE_PENDING;
      pc_d    = alloc_pc_i;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LANE_IDLE: state_d = LANE_IDLE;
        LANE_PENDING: begin
          if (commit_i) begin
            state_d = LANE_CHECK;
            cnt_d   = CW'(CHECK_LATENCY - 1);
          end else if (flush_i) begin
            state_d = LANE_RELEASE;
          end
        end
        LANE_CHECK: begin
          if (cnt_q == '0) state_d = LANE_RELEASE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        LANE_RELEASE: state_d = LANE_IDLE;
        default:      state_d = LANE_IDLE;
      endcase
    end
  end

  assign rec_o.state = state_q;
  assign rec_o.pc    = pc_q;

endmodule

// File: rtl/rm_lane_release.sv
// Runtime-monitor lane release tracker: allocates lanes, matches commits to the
// lowest pending lane with the same PC, and pulses a release request per lane.
module rm_lane_release
  import ariane_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned NUM_EVENTS    = 10,
  parameter int unsigned CHECK_LATENCY = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  runtime_monitor_ctrl            monitor_i,
  input  logic                           commit_valid_i,
  input  logic [riscv::VLEN-1:0]         commit_pc_i,
  output lane_ctrl                       reset_monitor_o [NUM_EVENTS],
  output logic [$clog2(NUM_LANES+1)-1:0] occupancy_o,
  output logic                           alloc_err_o
);

  localparam int unsigned OCC_W = $clog2(NUM_LANES + 1);

  lane_rec_t            rec [NUM_LANES];
  logic [NUM_LANES-1:0] alloc_hit;
  logic [NUM_LANES-1:0] commit_hit;
  logic [NUM_LANES-1:0] busy;
  logic                 err_q;
  logic                 found;
  logic [OCC_W-1:0]     occ;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign alloc_hit[g] = monitor_i.monitor_ins && !flush_i &&
                          (monitor_i.lane == RM_LANE_W'(g));
    assign busy[g]      = (rec[g].state == LANE_PENDING) ||
                          (rec[g].state == LANE_CHECK);

    rm_lane_slot #(
      .CHECK_LATENCY (CHECK_LATENCY)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .alloc_i    (alloc_hit[g]),
      .alloc_pc_i (monitor_i.pc),
      .commit_i   (commit_hit[g]),
      .flush_i    (flush_i),
      .rec_o      (rec[g])
    );
  end

  // A single commit retires at most one lane: the lowest-index pending match.
  always_comb begin
    commit_hit = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!found && commit_valid_i && (rec[i].state == LANE_PENDING) &&
          (rec[i].pc == commit_pc_i)) begin
        commit_hit[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | (|(alloc_hit & busy));
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rec[i].state != LANE_IDLE) occ = occ + OCC_W'(1);
    end
  end

  assign occupancy_o = occ;
  assign alloc_err_o = err_q;

  // Lane id is masked by reset so every release port reads all-zero in reset.
  for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_evt
    if (e < NUM_LANES) begin : g_live
      assign reset_monitor_o[e].reset_lane = (rec[e].state == LANE_RELEASE);
      assign reset_monitor_o[e].lane       = rst_ni ? RM_LANE_W'(e) : '0;
    end else begin : g_tie
      assign reset_monitor_o[e] = '0;
    end
  end

endmodule

// File: tb/tb_rm_lane_release.sv
// Directed bench for rm_lane_release: allocation, commit priority, flush,
// release-window re-allocation, sticky error and asynchronous reset.
module tb_rm_lane_release;
  import ariane_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned NE = 10;

  logic                   clk_i;
  logic                   rst_ni;
  logic                   flush_i;
  runtime_monitor_ctrl    monitor_i;
  logic                   commit_valid_i;
  logic [riscv::VLEN-1:0] commit_pc_i;
  lane_ctrl               reset_monitor_o [NE];
  logic [2:0]             occupancy_o;
  logic                   alloc_err_o;

  int n_checks = 0;
  int n_errors = 0;

  rm_lane_release #(
    .NUM_LANES     (NL),
    .NUM_EVENTS    (NE),
    .CHECK_LATENCY (3)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .monitor_i      (monitor_i),
    .commit_valid_i (commit_valid_i),
    .commit_pc_i    (commit_pc_i),
    .reset_monitor_o(reset_monitor_o),
    .occupancy_o    (occupancy_o),
    .alloc_err_o    (alloc_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares release bits against a lane mask and lane ids against i (or 0 in reset).
  task automatic check_rel(input string tag, input logic [NL-1:0] mask, input bit in_reset);
    logic [63:0] obs_rl, exp_rl, obs_ln, exp_ln;
    obs_rl = '0; exp_rl = '0; obs_ln = '0; exp_ln = '0;
    for (int i = 0; i < NE; i++) begin
      obs_rl[i] = reset_monitor_o[i].reset_lane;
      obs_ln[i*4 +: 4] = reset_monitor_o[i].lane;
      if (i < NL) begin
        exp_rl[i] = mask[i];
        if (!in_reset) exp_ln[i*4 +: 4] = 4'(i);
      end
    end
    check({tag, "_rel"}, obs_rl, exp_rl);
    check({tag, "_lane"}, obs_ln, exp_ln);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    monitor_i      = '0;
    commit_valid_i = 1'b0;
    commit_pc_i    = '0;
    flush_i        = 1'b0;
  endtask

  task automatic alloc(input int lane, input logic [63:0] pc);
    monitor_i.monitor_ins = 1'b1;
    monitor_i.lane        = 4'(lane);
    monitor_i.pc          = pc;
  endtask

  task automatic commit(input logic [63:0] pc);
    commit_valid_i = 1'b1;
    commit_pc_i    = pc;
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    #1;
    check("rst_occ", 64'(occupancy_o), 64'd0);
    check("rst_err", 64'(alloc_err_o), 64'd0);
    check_rel("rst", 4'b0000, 1'b1);
    step(); step();
    rst_ni = 1'b1;
    step();
    check_rel("post_rst", 4'b0000, 1'b0);

    // Single lane: commit-to-release of three edges, one-cycle pulse.
    alloc(2, 64'h8000_0010); step(); idle();
    check("t1_occ_pend", 64'(occupancy_o), 64'd1);
    check_rel("t1_pend", 4'b0000, 1'b0);
    commit(64'h8000_0010); step(); idle();
    check_rel("t1_c0", 4'b0000, 1'b0);
    step(); check_rel("t1_c1", 4'b0000, 1'b0);
    step(); check_rel("t1_c2", 4'b0000, 1'b0);
    step(); check_rel("t1_release", 4'b0100, 1'b0);
    step(); check_rel("t1_after", 4'b0000, 1'b0);
    check("t1_occ_end", 64'(occupancy_o), 64'd0);

    // Two lanes with the same PC: lowest index wins, a miss changes nothing.
    alloc(0, 64'h100); step();
    alloc(1, 64'h100); step(); idle();
    check("t2_occ", 64'(occupancy_o), 64'd2);
    commit(64'h100); step(); idle();
    commit(64'h200); step(); idle();
    check("t2_occ_miss", 64'(occupancy_o), 64'd2);
    commit(64'h100); step(); idle();
    check_rel("t2_c3", 4'b0000, 1'b0);
    step(); check_rel("t2_rel0", 4'b0001, 1'b0);
    step(); check_rel("t2_gap", 4'b0000, 1'b0);
    check("t2_occ_one", 64'(occupancy_o), 64'd1);
    step(); check_rel("t2_rel1", 4'b0010, 1'b0);
    step(); check("t2_occ_end", 64'(occupancy_o), 64'd0);

    // Flush: pending lanes release, checking lane keeps schedule, flushed alloc ignored.
    alloc(0, 64'hA0); step();
    alloc(3, 64'hB0); step();
    alloc(1, 64'hC0); step(); idle();
    commit(64'hC0); step(); idle();
    check("t3_occ3", 64'(occupancy_o), 64'd3);
    flush_i = 1'b1; alloc(2, 64'hD0); step(); idle();
    check_rel("t3_flush", 4'b1001, 1'b0);
    check("t3_occ_flush", 64'(occupancy_o), 64'd3);
    step(); check_rel("t3_c0", 4'b0000, 1'b0);
    check("t3_occ1", 64'(occupancy_o), 64'd1);
    step(); check_rel("t3_rel1", 4'b0010, 1'b0);
    step(); check("t3_occ0", 64'(occupancy_o), 64'd0);

    // Commit match and flush in the same cycle.
    alloc(0, 64'h10); step();
    alloc(1, 64'h20); step(); idle();
    commit(64'h20); flush_i = 1'b1; step(); idle();
    check_rel("t4_flush", 4'b0001, 1'b0);
    check("t4_occ2", 64'(occupancy_o), 64'd2);
    step(); check("t4_occ1", 64'(occupancy_o), 64'd1);
    step(); check_rel("t4_c2", 4'b0000, 1'b0);
    step(); check_rel("t4_rel1", 4'b0010, 1'b0);
    step(); check("t4_occ0", 64'(occupancy_o), 64'd0);

    // Re-allocation during the release cycle wins without an error.
    alloc(1, 64'h300); step(); idle();
    commit(64'h300); step(); idle();
    step(); step();
    step(); check_rel("t5_release", 4'b0010, 1'b0);
    alloc(1, 64'h400); step(); idle();
    check_rel("t5_realloc", 4'b0000, 1'b0);
    check("t5_occ", 64'(occupancy_o), 64'd1);
    check("t5_err", 64'(alloc_err_o), 64'd0);
    commit(64'h300); step(); idle();
    commit(64'h400); step(); idle();
    step(); step();
    step(); check_rel("t5_rel_new", 4'b0010, 1'b0);
    step(); check("t5_occ0", 64'(occupancy_o), 64'd0);

    // Allocation into a checking lane raises the sticky error.
    check("t6_err_pre", 64'(alloc_err_o), 64'd0);
    alloc(0, 64'h500); step(); idle();
    commit(64'h500); step(); idle();
    alloc(0, 64'h600); step(); idle();
    check("t6_err", 64'(alloc_err_o), 64'd1);
    check("t6_occ", 64'(occupancy_o), 64'd1);
    step(); step();
    check("t6_err_hold", 64'(alloc_err_o), 64'd1);

    // Asynchronous reset mid-check drops the pending release.
    commit(64'h600); step(); idle();
    #2 rst_ni = 1'b0;
    #1;
    check("t7_occ", 64'(occupancy_o), 64'd0);
    check("t7_err", 64'(alloc_err_o), 64'd0);
    check_rel("t7_rst", 4'b0000, 1'b1);
    step(); step();
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_rel("t7_quiet", 4'b0000, 1'b0);
    end
    check("t7_occ_end", 64'(occupancy_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rm_lane_release.md
RM_LANE_RELEASE -- requirements
Module: rm_lane_release

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of monitor lanes (power of two, >=2).
REQ-002 SHALL have parameter NUM_EVENTS, default 10, number of release ports (NUM_EVENTS >= NUM_LANES).
REQ-003 SHALL have parameter CHECK_LATENCY, default 3, cycles between commit match and release (1..15).
REQ-004 SHALL have port clk_i  input  1  clock.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_i  input  1  pipeline flush, squashes uncommitted lanes.
REQ-007 SHALL have port monitor_i  input  ariane_pkg::runtime_monitor_ctrl  allocation notice (monitor_ins, lane, pc).
REQ-008 SHALL have port commit_valid_i  input  1  one instruction commits this cycle.
REQ-009 SHALL have port commit_pc_i  input  riscv::VLEN  PC of committing instruction.
REQ-010 SHALL have port reset_monitor_o  output  ariane_pkg::lane_ctrl [NUM_EVENTS]  lane release requests (reset_lane, lane).
REQ-011 SHALL have port occupancy_o  output  $clog2(NUM_LANES+1)  number of lanes not IDLE.
REQ-012 SHALL have port alloc_err_o  output  1  sticky: allocation into busy lane.

Function
REQ-013 Each lane SHALL have an FSM: IDLE, PENDING, CHECK, RELEASE, plus a stored PC and a down-counter of $clog2(CHECK_LATENCY+1) bits.
REQ-014 monitor_i.monitor_ins=1 and flush_i=0 SHALL move lane monitor_i.lane to PENDING and store monitor_i.pc next cycle.
REQ-015 Allocation with flush_i=1 SHALL be ignored.
REQ-016 Allocation into a RELEASE lane SHALL win (lane -> PENDING, new PC); no error.
REQ-017 Allocation into a PENDING or CHECK lane SHALL overwrite that lane (-> PENDING) and set alloc_err_o until reset.
REQ-018 commit_valid_i=1 SHALL advance exactly one lane: lowest-index PENDING lane whose stored PC equals commit_pc_i, to CHECK with counter=CHECK_LATENCY-1.
REQ-019 No matching PENDING lane SHALL mean no state change.
REQ-020 CHECK SHALL decrement each cycle and go to RELEASE the cycle after counter reaches 0 (commit-to-release = CHECK_LATENCY cycles).
REQ-021 flush_i=1 SHALL move every PENDING lane to RELEASE; CHECK lanes unaffected (already committed).
REQ-022 Commit match and flush in the same cycle: the matched lane SHALL go to CHECK; other PENDING lanes to RELEASE.
REQ-023 RELEASE SHALL last exactly one cycle, then IDLE unless re-allocated per REQ-016.
REQ-024 reset_monitor_o[i], i<NUM_LANES, SHALL be combinational from lane i: reset_lane=(state==RELEASE), lane=i.
REQ-025 reset_monitor_o[i], i>=NUM_LANES, SHALL be driven all-zero.
REQ-026 occupancy_o SHALL be registered-state derived (count of non-IDLE lanes), no input-to-output path.

Reset
REQ-027 On rst_ni low all lanes SHALL be IDLE, PCs and counters 0, alloc_err_o=0, occupancy_o=0, all reset_monitor_o=0, immediately and asynchronously.
REQ-028 Reset mid-operation SHALL drop pending releases without emitting them.

Structure
REQ-029 Lane state enum and lane-record typedef SHALL live in ariane_pkg beside lane_ctrl and runtime_monitor_ctrl.
REQ-030 Per-lane FSM+counter SHALL be sub-module rm_lane_slot, instantiated NUM_LANES times; top holds commit priority match, error flag, occupancy.

Verification
REQ-031 Alloc lane 2 pc=0x80000010; commit pc=0x80000010 at cycle t -> reset_monitor_o[2].reset_lane=1 exactly at t+3, lane=2, one cycle.
REQ-032 Lanes 0,1 PENDING both pc=0x100; one commit pc=0x100 -> lane 0 to CHECK, lane 1 stays PENDING; second commit releases lane 1.
REQ-033 Lanes 0,3 PENDING, lane 1 CHECK; flush_i=1 -> lanes 0,3 released next cycle, lane 1 released on its schedule; occupancy_o 3->1->0.
REQ-034 Lane 1 in RELEASE and allocation to lane 1 same cycle -> lane 1 PENDING with new PC, no error, occupancy unchanged.
REQ-035 Allocation into CHECK lane 0 -> alloc_err_o=1 held until rst_ni low.
REQ-036 rst_ni low while lane in CHECK -> all outputs 0 asynchronously, no release pulse after reset deasserts.
